move_seq: RTL and testbench
===========================

Name: move_seq

Overview:
- Move sequencer that drives the PID steering controller for one knight-move leg.
- Accepts a command {desired heading, square count}. Turns in place to the heading, ramps forward speed up, and counts line crossings from the centre IR sensor. It then ramps down to a stop and pulses done.
- Generates the PID's `moving`, `frwrd`, `error` and `err_vld` inputs from the gyro heading stream.
- Sits between the command processor and the PID block.

Parameters:
- `HDG_TOL`, 12'h02C: |heading error| at or below this value ends the turn-in-place phase.
- `FRWRD_MAX`, 10'h300: cruise forward speed; the ramp saturates here.
- `RAMP_INC`, 6'h04: `frwrd` step applied per `heading_rdy` during ramp up/down.
- `SETTLE_CNT`, 4'h8: consecutive in-tolerance `heading_rdy` samples needed before leaving the turn phase.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `cmd_vld`  in  1  command valid
- `cmd_hdg`  in  12  desired heading, signed
- `cmd_sqrs`  in  4  squares to travel; 0 means turn only
- `cmd_rdy`  out  1  block idle, will accept a command
- `heading`  in  12  current gyro heading, signed
- `heading_rdy`  in  1  one-cycle strobe, `heading` is valid
- `cntrIR`  in  1  centre line sensor, level, asynchronous
- `error`  out  12  heading − desired heading, signed, wraps modulo 2^12
- `err_vld`  out  1  one-cycle strobe aligned with `error`
- `frwrd`  out  10  forward speed to PID
- `moving`  out  1  PID enable
- `move_done`  out  1  one-cycle pulse at leg completion

Behaviour:
- Reset (synchronous, `rst`=1 at a clk edge):
  - state=IDLE; `frwrd`=0, `moving`=0, `error`=0, `err_vld`=0, `move_done`=0, `cmd_rdy`=1.
  - Desired heading register = 0; line count = 0; settle count = 0.
  - Reset mid-operation aborts the leg immediately; no `move_done` is issued.
- Command handshake:
  - A command is captured when `cmd_vld & cmd_rdy`.
  - `cmd_rdy`=1 only in IDLE; a `cmd_vld` in any other state is ignored.
  - Capture latches `cmd_hdg`, latches target=`cmd_sqrs`×2 (two line crossings per square), clears the counters, and moves IDLE→TURN.
- Error path, all states except IDLE:
  - On `heading_rdy`, register `error` = `heading` − desired (12-bit wrap) and `err_vld`=1 the next cycle, for one cycle.
  - Latency heading_rdy→err_vld is 1 clk.
  - In IDLE, `err_vld` stays 0.
- `cntrIR` input conditioning:
  - Double-flop synchronised, then rising-edge detected.
  - Edges increment the line count only in RAMP_UP and CRUISE.
- States and transitions:
  - IDLE: `moving`=0, `frwrd`=0.
  - TURN: `moving`=1, `frwrd`=0.
    - On each `heading_rdy`: if |heading − desired| ≤ `HDG_TOL`, settle count +1; otherwise clear it.
    - Settle count reaching `SETTLE_CNT` → RAMP_UP if target ≠ 0, else DONE.
  - RAMP_UP: on each `heading_rdy`, `frwrd` += `RAMP_INC`, saturating at `FRWRD_MAX`. Reaching `FRWRD_MAX` → CRUISE.
  - CRUISE: `frwrd` held.
  - Exits from RAMP_UP and CRUISE: line count == target → RAMP_DN. This check has priority over the RAMP_UP → CRUISE transition in the same cycle.
  - RAMP_DN: on each `heading_rdy`, `frwrd` −= `RAMP_INC`, saturating at 0. `frwrd`==0 → DONE.
  - DONE: `move_done`=1 for exactly one cycle, `moving`=0, `frwrd`=0, then → IDLE.
- Arithmetic and widths:
  - |err| is computed on the 12-bit wrapped difference; −2048 maps to 2047.
  - Ramp add/subtract is done 11 bits wide with compare-and-clamp, so the ramp never wraps.
  - Line count is 5 bits, enough for the maximum target of 30.
- Simultaneous events:
  - `heading_rdy` and a line edge in the same cycle: both take effect.
  - Line count reaching target during RAMP_UP freezes ramp-up and starts RAMP_DN from the current `frwrd`.

Decomposition:
- Package `move_seq_pkg`:
  - state enum `mv_state_t` {IDLE, TURN, RAMP_UP, CRUISE, RAMP_DN, DONE};
  - default constants for `HDG_TOL`, `FRWRD_MAX`, `RAMP_INC`, `SETTLE_CNT`.
- Sub-module `ir_edge_det`: 2-flop synchroniser plus rising-edge pulse, with synchronous active-high reset.
- The ramp, error and FSM logic stay in `move_seq`.

Test Plan:
- Reset during CRUISE (`frwrd`=0x300) → next cycle `frwrd`=0, `moving`=0, `cmd_rdy`=1; no `move_done`.
- `cmd_hdg`=0x3FF, `cmd_sqrs`=1, `heading` starts at 0x000 → `error`=0xC01 on the first `err_vld`. Then drive `heading`=0x3F0 for 8 strobes → RAMP_UP. `frwrd` climbs by 4 per strobe to 0x300. After 2 `cntrIR` pulses, ramps to 0 and `move_done` pulses once.
- `cmd_sqrs`=0 with `heading`=desired → after 8 `heading_rdy`: `move_done`, `frwrd` never non-zero.
- Wrap case: desired=0x7F0, `heading`=0x810 → `error`=0x020, within tolerance, settle count increments.
- Two line edges arrive while RAMP_UP `frwrd`=0x040 → RAMP_DN from 0x040; 16 strobes later `frwrd`=0, `move_done`.
- `cmd_vld` asserted during RAMP_DN with a new heading → ignored; desired heading unchanged; `cmd_rdy` stays 0 until IDLE.

Source files
------------

// File: rtl/move_seq_pkg.sv
// Shared types and default tuning constants for the knight-move leg sequencer.
package move_seq_pkg;

    localparam int unsigned HDG_W    = 12;
    localparam int unsigned FRWRD_W  = 10;
    localparam int unsigned INC_W    = 6;
    localparam int unsigned SETTLE_W = 4;
    localparam int unsigned LINE_W   = 5;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        RAMP_UP,
        CRUISE,
        RAMP_DN,
        DONE
    } mv_state_t;

    localparam logic [HDG_W-1:0]    HDG_TOL_DEF    = 12'h02C;
    localparam logic [FRWRD_W-1:0]  FRWRD_MAX_DEF  = 10'h300;
    localparam logic [INC_W-1:0]    RAMP_INC_DEF   = 6'h04;
    localparam logic [SETTLE_W-1:0] SETTLE_CNT_DEF = 4'h8;

    // Magnitude of a wrapped heading error; the most negative code saturates.
    function automatic logic [HDG_W-1:0] abs_err(input logic [HDG_W-1:0] e);
        if (e == 12'h800)
            return 12'h7FF;
        else if (e[HDG_W-1])
            return HDG_W'(-e);
        else
            return e;
    endfunction

endpackage

// File: rtl/move_seq_ir.sv
// Centre IR line sensor conditioning: two-flop synchroniser and rising-edge pulse.
module ir_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sync1, sync2, sync3;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            sync3 <= sync2;
            rise  <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/move_seq.sv
// Sequences one leg: turn in place, ramp up, count line crossings, ramp down, done.
module move_seq
    import move_seq_pkg::*;
#(
    parameter logic [HDG_W-1:0]    HDG_TOL    = HDG_TOL_DEF,
    parameter logic [FRWRD_W-1:0]  FRWRD_MAX  = FRWRD_MAX_DEF,
    parameter logic [INC_W-1:0]    RAMP_INC   = RAMP_INC_DEF,
    parameter logic [SETTLE_W-1:0] SETTLE_CNT = SETTLE_CNT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_vld,
    input  logic [HDG_W-1:0]   cmd_hdg,
    input  logic [3:0]         cmd_sqrs,
    output logic               cmd_rdy,
    input  logic [HDG_W-1:0]   heading,
    input  logic               heading_rdy,
    input  logic               cntrIR,
    output logic [HDG_W-1:0]   error,
    output logic               err_vld,
    output logic [FRWRD_W-1:0] frwrd,
    output logic               moving,
    output logic               move_done
);

    mv_state_t            state, state_nx;
    logic [HDG_W-1:0]     des_hdg, des_hdg_nx;
    logic [LINE_W-1:0]    target, target_nx;
    logic [LINE_W-1:0]    line_cnt, line_cnt_nx;
    logic [SETTLE_W-1:0]  settle_cnt, settle_cnt_nx;
    logic [FRWRD_W-1:0]   frwrd_nx;
    logic [HDG_W-1:0]     error_nx;
    logic                 err_vld_nx, moving_nx, cmd_rdy_nx, move_done_nx;

    logic                 ir_rise;
    logic [HDG_W-1:0]     err_diff;
    logic                 in_tol;
    logic [SETTLE_W-1:0]  settle_inc;
    logic [FRWRD_W:0]     ramp_sum, ramp_dif;
    logic [FRWRD_W-1:0]   up_val, dn_val;

    ir_edge_det u_ir (
        .clk  (clk),
        .rst  (rst),
        .din  (cntrIR),
        .rise (ir_rise)
    );

    // Ramp math is one bit wider than frwrd so it clamps instead of wrapping.
    always_comb begin
        err_diff   = HDG_W'(heading - des_hdg);
        in_tol     = abs_err(err_diff) <= HDG_TOL;
        settle_inc = SETTLE_W'(settle_cnt + 4'd1);
        ramp_sum   = {1'b0, frwrd} + (FRWRD_W+1)'(RAMP_INC);
        ramp_dif   = {1'b0, frwrd} - (FRWRD_W+1)'(RAMP_INC);
        up_val     = (ramp_sum >= {1'b0, FRWRD_MAX}) ? FRWRD_MAX : ramp_sum[FRWRD_W-1:0];
        dn_val     = ramp_dif[FRWRD_W] ? '0 : ramp_dif[FRWRD_W-1:0];
    end

    always_comb begin
        state_nx      = state;
        des_hdg_nx    = des_hdg;
        target_nx     = target;
        line_cnt_nx   = line_cnt;
        settle_cnt_nx = settle_cnt;
        frwrd_nx      = frwrd;
        error_nx      = error;
        err_vld_nx    = 1'b0;

        if (heading_rdy && state != IDLE) begin
            error_nx   = err_diff;
            err_vld_nx = 1'b1;
        end

        if (ir_rise && (state == RAMP_UP || state == CRUISE))
            line_cnt_nx = LINE_W'(line_cnt + 5'd1);

        case (state)
            IDLE: begin
                frwrd_nx = '0;
                if (cmd_vld && cmd_rdy) begin
                    des_hdg_nx    = cmd_hdg;
                    target_nx     = {cmd_sqrs, 1'b0};
                    line_cnt_nx   = '0;
                    settle_cnt_nx = '0;
                    state_nx      = TURN;
                end
            end
            TURN: begin
                frwrd_nx = '0;
                if (heading_rdy) begin
                    if (in_tol) begin
                        settle_cnt_nx = settle_inc;
                        if (settle_inc == SETTLE_CNT)
                            state_nx = (target != '0) ? RAMP_UP : DONE;
                    end else begin
                        settle_cnt_nx = '0;
                    end
                end
            end
            RAMP_UP: begin
                // Reaching the line target wins over finishing the ramp.
                if (line_cnt == target) begin
                    state_nx = RAMP_DN;
                end else if (heading_rdy) begin
                    frwrd_nx = up_val;
                    if (up_val == FRWRD_MAX)
                        state_nx = CRUISE;
                end
            end
            CRUISE: begin
                if (line_cnt == target)
                    state_nx = RAMP_DN;
            end
            RAMP_DN: begin
                if (frwrd == '0)
                    state_nx = DONE;
                else if (heading_rdy)
                    frwrd_nx = dn_val;
            end
            DONE: begin
                frwrd_nx = '0;
                state_nx = IDLE;
            end
            default: begin
                frwrd_nx = '0;
                state_nx = IDLE;
            end
        endcase

        moving_nx    = (state_nx == TURN) || (state_nx == RAMP_UP) ||
                       (state_nx == CRUISE) || (state_nx == RAMP_DN);
        cmd_rdy_nx   = (state_nx == IDLE);
        move_done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            des_hdg    <= '0;
            target     <= '0;
            line_cnt   <= '0;
            settle_cnt <= '0;
            frwrd      <= '0;
            error      <= '0;
            err_vld    <= 1'b0;
            moving     <= 1'b0;
            cmd_rdy    <= 1'b1;
            move_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            des_hdg    <= des_hdg_nx;
            target     <= target_nx;
            line_cnt   <= line_cnt_nx;
            settle_cnt <= settle_cnt_nx;
            frwrd      <= frwrd_nx;
            error      <= error_nx;
            err_vld    <= err_vld_nx;
            moving     <= moving_nx;
            cmd_rdy    <= cmd_rdy_nx;
            move_done  <= move_done_nx;
        end
    end

endmodule

// File: tb/tb_move_seq.sv
// Self-checking bench for move_seq: randomized legs against a behavioural leg model.
module tb_move_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_vld;
    logic [11:0] cmd_hdg;
    logic [3:0]  cmd_sqrs;
    logic        cmd_rdy;
    logic [11:0] heading;
    logic        heading_rdy;
    logic        cntrIR;
    logic [11:0] error;
    logic        err_vld;
    logic [9:0]  frwrd;
    logic        moving;
    logic        move_done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int frwrd_nz = 0;

    move_seq dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_vld     (cmd_vld),
        .cmd_hdg     (cmd_hdg),
        .cmd_sqrs    (cmd_sqrs),
        .cmd_rdy     (cmd_rdy),
        .heading     (heading),
        .heading_rdy (heading_rdy),
        .cntrIR      (cntrIR),
        .error       (error),
        .err_vld     (err_vld),
        .frwrd       (frwrd),
        .moving      (moving),
        .move_done   (move_done)
    );

    always #5 clk = ~clk;

    // Monitors see last cycle's outputs at each rising edge.
    always @(posedge clk) begin
        if (move_done === 1'b1) done_cnt++;
        if (frwrd !== 10'd0) frwrd_nz++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: heading minus desired, taken modulo 4096.
    function automatic logic [11:0] exp_err(input int h, input int d);
        return 12'(((h - d) % 4096 + 4096) % 4096);
    endfunction

    function automatic bit exp_in_tol(input int h, input int d);
        int e;
        e = ((h - d) % 4096 + 4096) % 4096;
        if (e >= 2048) e = e - 4096;
        if (e < 0) e = -e;
        return e <= 44;
    endfunction

    function automatic logic [11:0] near(input logic [11:0] d);
        int off;
        off = int'($urandom_range(0, 88)) - 44;
        return 12'(((int'(d) + off) % 4096 + 4096) % 4096);
    endfunction

    task automatic send_cmd(input logic [11:0] h, input logic [3:0] s);
        @(negedge clk);
        cmd_vld  = 1'b1;
        cmd_hdg  = h;
        cmd_sqrs = s;
        @(negedge clk);
        cmd_vld  = 1'b0;
    endtask

    task automatic strobe(input logic [11:0] h);
        @(negedge clk);
        heading     = h;
        heading_rdy = 1'b1;
        @(negedge clk);
        heading_rdy = 1'b0;
    endtask

    task automatic ir_pulse();
        cntrIR = 1'b1;
        repeat (4) @(negedge clk);
        cntrIR = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // One complete leg; the model tracks expected speed from the ramp rules.
    task automatic run_leg(input logic [11:0] des, input int sqrs, input int n_ramp,
                           input bit probe_cmd, input bit first_zero);
        logic [11:0] h;
        int exp_f;
        int d0;
        checks++;
        if (cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL leg_rdy_idle: cmd_rdy=%b expected 1", cmd_rdy);
        end
        send_cmd(des, 4'(sqrs));
        checks++;
        if (cmd_rdy !== 1'b0 || moving !== 1'b1) begin
            failures++;
            $display("FAIL leg_accept: cmd_rdy=%b moving=%b expected 0/1", cmd_rdy, moving);
        end
        d0 = done_cnt;
        h = first_zero ? 12'h000 : (des ^ 12'h400);
        strobe(h);
        checks++;
        if (err_vld !== 1'b1 || error !== exp_err(int'(h), int'(des))) begin
            failures++;
            $display("FAIL turn_err_first: vld=%b error=%h expected 1/%h",
                     err_vld, error, exp_err(int'(h), int'(des)));
        end
        @(negedge clk);
        checks++;
        if (err_vld !== 1'b0) begin
            failures++;
            $display("FAIL err_vld_pulse: err_vld=%b expected 0", err_vld);
        end
        for (int i = 0; i < 8; i++) begin
            h = near(des);
            strobe(h);
            checks++;
            if (err_vld !== 1'b1 || error !== exp_err(int'(h), int'(des))) begin
                failures++;
                $display("FAIL turn_err: vld=%b error=%h expected 1/%h",
                         err_vld, error, exp_err(int'(h), int'(des)));
            end
        end
        if (sqrs == 0) begin
            checks++;
            if (move_done !== 1'b1 || frwrd !== 10'd0 || moving !== 1'b0) begin
                failures++;
                $display("FAIL turn_only_done: done=%b frwrd=%h moving=%b expected 1/000/0",
                         move_done, frwrd, moving);
            end
        end else begin
            checks++;
            if (moving !== 1'b1 || frwrd !== 10'd0) begin
                failures++;
                $display("FAIL turn_exit: moving=%b frwrd=%h expected 1/000", moving, frwrd);
            end
            exp_f = 0;
            for (int i = 0; i < n_ramp; i++) begin
                h = 12'($urandom_range(0, 4095));
                strobe(h);
                exp_f = (exp_f + 4 > 768) ? 768 : exp_f + 4;
                checks++;
                if (frwrd !== 10'(exp_f) || error !== exp_err(int'(h), int'(des))) begin
                    failures++;
                    $display("FAIL ramp_up: frwrd=%h error=%h expected %h/%h",
                             frwrd, error, 10'(exp_f), exp_err(int'(h), int'(des)));
                end
            end
            for (int k = 0; k < 2 * sqrs; k++) ir_pulse();
            repeat (8) @(negedge clk);
            if (exp_f > 0) begin
                checks++;
                if (frwrd !== 10'(exp_f) || moving !== 1'b1) begin
                    failures++;
                    $display("FAIL lines_hold: frwrd=%h moving=%b expected %h/1",
                             frwrd, moving, 10'(exp_f));
                end
            end
            if (probe_cmd && exp_f > 0) begin
                @(negedge clk);
                cmd_vld  = 1'b1;
                cmd_hdg  = des ^ 12'h555;
                cmd_sqrs = 4'd5;
                repeat (2) @(negedge clk);
                cmd_vld  = 1'b0;
                checks++;
                if (cmd_rdy !== 1'b0) begin
                    failures++;
                    $display("FAIL cmd_ignored_rdy: cmd_rdy=%b expected 0", cmd_rdy);
                end
            end
            while (exp_f > 0) begin
                h = 12'($urandom_range(0, 4095));
                strobe(h);
                exp_f = (exp_f - 4 < 0) ? 0 : exp_f - 4;
                checks++;
                if (frwrd !== 10'(exp_f) || error !== exp_err(int'(h), int'(des))) begin
                    failures++;
                    $display("FAIL ramp_dn: frwrd=%h error=%h expected %h/%h",
                             frwrd, error, 10'(exp_f), exp_err(int'(h), int'(des)));
                end
            end
        end
        for (int t = 0; t < 20 && done_cnt == d0; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL done_once: pulses=%0d expected 1", done_cnt - d0);
        end
        checks++;
        if (cmd_rdy !== 1'b1 || moving !== 1'b0 || frwrd !== 10'd0) begin
            failures++;
            $display("FAIL leg_end_idle: cmd_rdy=%b moving=%b frwrd=%h expected 1/0/000",
                     cmd_rdy, moving, frwrd);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (frwrd !== 10'd0 || moving !== 1'b0 || cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl: frwrd=%h moving=%b cmd_rdy=%b expected 000/0/1",
                     frwrd, moving, cmd_rdy);
        end
        checks++;
        if (error !== 12'h000 || err_vld !== 1'b0 || move_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_err: error=%h err_vld=%b done=%b expected 000/0/0",
                     error, err_vld, move_done);
        end
        strobe(12'h123);
        checks++;
        if (err_vld !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_err_vld: err_vld=%b expected 0", err_vld);
        end
    endtask

    task automatic test_full_leg();
        run_leg(12'h3FF, 1, 200, 1'b1, 1'b1);
    endtask

    task automatic test_turn_only();
        int nz0;
        nz0 = frwrd_nz;
        run_leg(12'h5A5, 0, 0, 1'b0, 1'b0);
        checks++;
        if (frwrd_nz != nz0) begin
            failures++;
            $display("FAIL turn_only_frwrd: nonzero_cycles=%0d expected 0", frwrd_nz - nz0);
        end
    endtask

    // Settle counting across the heading wrap, with random tolerance breaks.
    task automatic test_wrap();
        logic [11:0] des;
        logic [11:0] h;
        int consec;
        int n;
        des = 12'h7F0;
        send_cmd(des, 4'd0);
        strobe(12'h810);
        checks++;
        if (error !== 12'h020 || err_vld !== 1'b1) begin
            failures++;
            $display("FAIL wrap_err: error=%h vld=%b expected 020/1", error, err_vld);
        end
        consec = 1;
        n = 0;
        while (consec < 8 && n < 60) begin
            if (n < 30 && $urandom_range(0, 3) == 0)
                h = (n % 2 == 0) ? (des ^ 12'h800) : 12'(des + 12'h02D);
            else
                h = near(des);
            strobe(h);
            n++;
            consec = exp_in_tol(int'(h), int'(des)) ? consec + 1 : 0;
            checks++;
            if (error !== exp_err(int'(h), int'(des)) || move_done !== (consec == 8)) begin
                failures++;
                $display("FAIL settle: error=%h done=%b expected %h/%b",
                         error, move_done, exp_err(int'(h), int'(des)), consec == 8);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL wrap_idle: cmd_rdy=%b expected 1", cmd_rdy);
        end
    endtask

    task automatic test_ramp_abort();
        run_leg(12'h010, 1, 16, 1'b0, 1'b0);
    endtask

    task automatic test_reset_cruise();
        int d0;
        send_cmd(12'hC00, 4'd2);
        repeat (8) strobe(12'hC00);
        repeat (200) strobe(12'hC05);
        checks++;
        if (frwrd !== 10'h300) begin
            failures++;
            $display("FAIL cruise_speed: frwrd=%h expected 300", frwrd);
        end
        d0 = done_cnt;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (frwrd !== 10'd0 || moving !== 1'b0 || cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_cruise: frwrd=%h moving=%b cmd_rdy=%b expected 000/0/1",
                     frwrd, moving, cmd_rdy);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL reset_no_done: pulses=%0d expected 0", done_cnt - d0);
        end
    endtask

    task automatic test_random_legs();
        for (int i = 0; i < 4; i++)
            run_leg(12'($urandom_range(0, 4095)), int'($urandom_range(1, 3)),
                    int'($urandom_range(0, 200)), 1'b1, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        cmd_vld     = 1'b0;
        cmd_hdg     = '0;
        cmd_sqrs    = '0;
        heading     = '0;
        heading_rdy = 1'b0;
        cntrIR      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_full_leg();
        test_turn_only();
        test_wrap();
        test_ramp_abort();
        test_reset_cruise();
        test_random_legs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
